// File: rtl/reg_shift_out.sv
// Serial read-out of a WIDTH-bit register: start bit, data LSB first, stop bit,
// DIV clocks per bit, with BUSY/DONE handshake. All outputs are registered.
module reg_shift_out #(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN,
    input  logic             LD,
    output logic             TX,
    output logic             BUSY,
    output logic             DONE
);
    localparam int CW = (DIV   > 1) ? $clog2(DIV)   : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic             tx_nxt, busy_nxt, done_nxt;
    logic             wrap;

    assign wrap = (cnt == CW'(DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            TX    <= 1'b1;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            sh    <= sh_nxt;
            TX    <= tx_nxt;
            BUSY  <= busy_nxt;
            DONE  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = wrap ? '0 : cnt + CW'(1);
        idx_nxt   = idx;
        sh_nxt    = sh;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (LD) begin
                    state_nxt = START;
                    sh_nxt    = IN;
                end
            end
            START: if (wrap) begin
                state_nxt = DATA;
                idx_nxt   = '0;
            end
            DATA: if (wrap) begin
                sh_nxt = sh >> 1;
                if (idx == IW'(WIDTH - 1)) state_nxt = STOP;
                else                       idx_nxt   = idx + IW'(1);
            end
            STOP: if (wrap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so the registered line
    // already shows the new bit in the first cycle of each bit period.
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == STOP) && (state_nxt == IDLE);
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = sh_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end
endmodule
